signed_adder: RTL and testbench
===============================

// Module: signed_adder
// PURPOSE
//   Registered signed adder: sums two signed WIDTH-bit operands and presents
//   the full-precision (WIDTH+1)-bit signed result on a clocked output register.
//   Small arithmetic leaf for datapaths that need a pipelined, overflow-free
//   two's-complement sum with a synchronous clear.
//   Single clock domain. One register stage.
// PARAMETERS
//   WIDTH   4   operand width in bits (signed two's complement); result is WIDTH+1
// PORTS
//   clk   in   1          rising-edge clock
//   rst   in   1          synchronous, active-high reset
//   c     out  WIDTH+1    signed registered sum a+b
//   a     in   WIDTH      signed operand A
//   b     in   WIDTH      signed operand B
//   Positional port order is fixed as (c, a, b, clk, rst); instantiations connect by position.
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high: rst=1 at a rising clk edge
//     loads c <= 0. rst has no effect between edges; no asynchronous clear.
//   - Reset value of c: all zeros (0).
//   - When rst=0, on every rising clk edge: c <= sext(a) + sext(b), with both
//     operands sign-extended to WIDTH+1 bits before the add.
//   - Latency: 1 cycle. Operands sampled at edge N appear on c after edge N,
//     stable until edge N+1. No enable and no handshake: a new sum every cycle.
//   - Width rule: WIDTH+1 bits hold every possible sum, so there is no overflow
//     and no wrap-around. For WIDTH=4 the range is -16..+14.
//   - No saturation and no overflow flag; the result is exact.
//   - Reset mid-operation: a reset cycle discards the in-flight sum, so c=0 for
//     that cycle. The first edge with rst=0 loads the current a+b.
//   - Reset held for several cycles: c stays 0.
//   - X/Z on a or b while rst=0 propagates to c. While rst=1, c is a clean 0.
//   - c is driven only by the register; there is no combinational path from
//     a/b to c.
//   - Power-up value of c before the first reset edge is undefined; users must
//     apply reset.
// TESTING
//   - Reset: a=0, b=0, rst=1 for one edge -> c==0 (5'b00000). Repeat back-to-back -> c stays 0.
//   - Mixed extremes: a=7, b=-8 -> c==-1 after 1 edge. a=-8, b=7 -> c==-1.
//   - Positive max: a=7, b=7 -> c==14. a=7, b=0 -> 7. a=0, b=7 -> 7.
//   - Negative max: a=-8, b=-8 -> c==-16. a=-8, b=0 -> -8. a=0, b=-8 -> -8.
//   - Zero and latency: a=0, b=0 -> c==0. Change the operands each cycle and check
//     that c equals the sum of the previous edge's operands.
//   - Reset mid-stream: with a=7, b=7 running, assert rst for 1 edge -> c==0.
//     Deassert rst -> c==14 on the next edge.
//   Compare with !== (4-state compare). Stop on the first mismatch. Report pass and fail counts.

Source files
------------

// File: rtl/signed_adder.sv
`default_nettype none
// ============================================================================
// Module      : signed_adder
// Description : Registered signed adder. Sign-extends two WIDTH-bit
//               two's-complement operands to WIDTH+1 bits, adds them and
//               holds the exact sum in a single output register with a
//               synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_adder #(
  parameter int WIDTH = 4
) (
  output logic signed [WIDTH:0]   c,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    clk,
  input  logic                    rst
);

  // One extra bit of headroom holds every possible sum, so the add is exact.
  localparam int c_sum_w = WIDTH + 1;

  logic signed [c_sum_w-1:0] w_a_ext;
  logic signed [c_sum_w-1:0] w_b_ext;
  logic signed [c_sum_w-1:0] w_sum;
  logic signed [c_sum_w-1:0] r_c;

  // Sign-extend both operands before the add so the carry-out is kept.
  always_comb begin
    w_a_ext = {a[WIDTH-1], a};
    w_b_ext = {b[WIDTH-1], b};
    w_sum   = w_a_ext + w_b_ext;
  end

  // Output register: a reset edge clears it, otherwise it captures the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= '0;
    end else begin
      r_c <= w_sum;
    end
  end

  // The result is driven only from the register, never from the operands.
  assign c = r_c;

endmodule
`default_nettype wire

// File: tb/tb_signed_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_adder
// Description : Directed-vector self-checking bench for signed_adder
//               (WIDTH = 4, result 5 bits, range -16..+14).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_adder;

  localparam int WIDTH = 4;

  logic                    clk;
  logic                    rst;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic signed [WIDTH:0]   c;

  int checks;
  int failures;

  signed_adder #(.WIDTH(WIDTH)) u_dut (
    .c   (c),
    .a   (a),
    .b   (b),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Four-state compare; the run ends at the first mismatch.
  task automatic check_eq(input string tag, input logic signed [WIDTH:0] got,
                          input logic signed [WIDTH:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (%b) expected %0d (%b)", tag, got, got, exp, exp);
      finish_run();
    end
  endtask

  // Drive operands and reset away from the edge, clock once, sample #1 later.
  task automatic step(input logic signed [WIDTH-1:0] va,
                      input logic signed [WIDTH-1:0] vb,
                      input logic                    vrst);
    @(negedge clk);
    a   = va;
    b   = vb;
    rst = vrst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    a   = '0;
    b   = '0;
    rst = 1'b1;

    // Reset, then held back-to-back.
    step(4'sd0, 4'sd0, 1'b1);
    check_eq("reset_1", c, 5'sd0);
    step(4'sd0, 4'sd0, 1'b1);
    check_eq("reset_2", c, 5'sd0);
    step(4'sd5, 4'sd6, 1'b1);
    check_eq("reset_held_nonzero_ops", c, 5'sd0);

    // Mixed extremes.
    step(4'sd7, -4'sd8, 1'b0);
    check_eq("7+-8", c, -5'sd1);
    step(-4'sd8, 4'sd7, 1'b0);
    check_eq("-8+7", c, -5'sd1);

    // Positive maximum.
    step(4'sd7, 4'sd7, 1'b0);
    check_eq("7+7", c, 5'sd14);
    step(4'sd7, 4'sd0, 1'b0);
    check_eq("7+0", c, 5'sd7);
    step(4'sd0, 4'sd7, 1'b0);
    check_eq("0+7", c, 5'sd7);

    // Negative maximum.
    step(-4'sd8, -4'sd8, 1'b0);
    check_eq("-8+-8", c, -5'sd16);
    step(-4'sd8, 4'sd0, 1'b0);
    check_eq("-8+0", c, -5'sd8);
    step(4'sd0, -4'sd8, 1'b0);
    check_eq("0+-8", c, -5'sd8);

    // Zero and a changing stream: c follows the previous edge's operands.
    step(4'sd0, 4'sd0, 1'b0);
    check_eq("0+0", c, 5'sd0);
    step(4'sd3, -4'sd5, 1'b0);
    check_eq("3+-5", c, -5'sd2);
    step(-4'sd1, -4'sd1, 1'b0);
    check_eq("-1+-1", c, -5'sd2);
    step(4'sd5, 4'sd2, 1'b0);
    check_eq("5+2", c, 5'sd7);
    step(-4'sd3, 4'sd6, 1'b0);
    check_eq("-3+6", c, 5'sd3);

    // Registered output: operand changes between edges must not reach c.
    a = -4'sd8;
    b = -4'sd8;
    #2;
    check_eq("no_comb_path", c, 5'sd3);

    // Reset mid-stream.
    step(4'sd7, 4'sd7, 1'b0);
    check_eq("stream_7+7", c, 5'sd14);
    step(4'sd7, 4'sd7, 1'b1);
    check_eq("midstream_reset", c, 5'sd0);
    step(4'sd7, 4'sd7, 1'b0);
    check_eq("after_reset_7+7", c, 5'sd14);

    finish_run();
  end

endmodule
`default_nettype wire
